// File: rtl/flash_pkg.sv
// Shared widths and FSM encoding for the flash arbiter slice.
package flash_pkg;

  localparam int FLASH_AW = 24;
  localparam int FLASH_DW = 32;
  localparam int NUM_REQ  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/flash_rr_arb.sv
// Combinational two-way round-robin picker. 'last' is the index of the
// requester served most recently; on a tie the other one wins.
module flash_rr_arb
  import flash_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] grant
);

  // One-hot grant: a sole requester always wins, a tie goes away from 'last'
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/flash_arbiter.sv
// Two-requester arbiter for an asynchronous-style parallel flash.
// Each transaction runs IDLE -> SETUP -> ACCESS -> DONE; the winner's
// command is latched in IDLE and held on f_addr/f_wdata until DONE.
// Optional read timeout is built when FLASH_ARB_TIMEOUT_EN is defined.
module flash_arbiter
  import flash_pkg::*;
#(
  parameter int WR_CYCLES = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 m_req,
  input  logic [NUM_REQ-1:0]                 m_we,
  input  logic [NUM_REQ-1:0][FLASH_AW-1:0]   m_addr,
  input  logic [NUM_REQ-1:0][FLASH_DW-1:0]   m_wdata,
  output logic [NUM_REQ-1:0]                 m_ack,
  output logic [NUM_REQ-1:0]                 m_err,
  output logic [FLASH_DW-1:0]                m_rdata,
  output logic                               f_cs_n,
  output logic                               f_oe_n,
  output logic                               f_we_n,
  output logic [FLASH_AW-1:0]                f_addr,
  output logic [FLASH_DW-1:0]                f_wdata,
  input  logic [FLASH_DW-1:0]                f_rdata,
  input  logic                               f_ready
);

  if (WR_CYCLES < 1 || WR_CYCLES > 255 || TIMEOUT < 1) begin : g_param_check
    $error("flash_arbiter: WR_CYCLES must be 1..255 and TIMEOUT >= 1");
  end

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  grant;
  logic                gnt_idx;
  logic                win_q;
  logic                last_q;
  logic                we_q;
  logic [FLASH_AW-1:0] addr_q;
  logic [FLASH_DW-1:0] wdata_q;
  logic [FLASH_DW-1:0] rdata_q;
  logic [7:0]          wr_cnt;
  logic                wr_last;
  logic                rd_timeout;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]    tmo_cnt;
  logic                err_q;
  assign rd_timeout = !f_ready && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  assign rd_timeout = 1'b0;
`endif

  flash_rr_arb u_rr_arb (
    .req   (m_req),
    .last  (last_q),
    .grant (grant)
  );

  assign gnt_idx = grant[1];
  assign wr_last = (wr_cnt == 8'(WR_CYCLES - 1));
  assign f_addr  = addr_q;
  assign f_wdata = wdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: strictly IDLE -> SETUP -> ACCESS -> DONE -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (|grant) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (we_q) begin
          if (wr_last) state_nxt = ST_DONE;
        end else if (f_ready || rd_timeout) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, cycle counters and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_cnt  <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
      tmo_cnt <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            win_q   <= gnt_idx;
            we_q    <= m_we[gnt_idx];
            addr_q  <= m_addr[gnt_idx];
            wdata_q <= m_wdata[gnt_idx];
            wr_cnt  <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
            err_q   <= 1'b0;
`endif
          end
        end
        ST_ACCESS: begin
          wr_cnt <= wr_cnt + 8'd1;
`ifdef FLASH_ARB_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!we_q && rd_timeout) err_q <= 1'b1;
`endif
        end
        ST_DONE: last_q <= win_q;
        default: ;
      endcase
    end
  end

  // Read-data capture; a timed-out read returns zero
  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && !we_q) begin
      if (f_ready)         rdata_q <= f_rdata;
      else if (rd_timeout) rdata_q <= '0;
    end
  end

  // Strobes and requester-side outputs decoded from state
  always_comb begin
    f_cs_n  = 1'b1;
    f_oe_n  = 1'b1;
    f_we_n  = 1'b1;
    m_ack   = '0;
    m_err   = '0;
    m_rdata = '0;
    case (state)
      ST_SETUP:  f_cs_n = 1'b0;
      ST_ACCESS: begin
        f_cs_n = 1'b0;
        f_oe_n = we_q;
        f_we_n = !we_q;
      end
      ST_DONE: begin
        m_ack[win_q] = 1'b1;
`ifdef FLASH_ARB_TIMEOUT_EN
        m_err[win_q] = err_q;
`endif
        if (!we_q) m_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule
